// File: rtl/bcd_entry_validator.sv
// bcd_entry_validator
//
// Collects keypad digits into a BCD entry buffer. The buffer supports clear
// and backspace. On enter it converts the buffer to binary one digit per
// cycle, starting with the most significant digit. It then flags whether
// the committed value is above MAX_VAL.
//
// Ports:
//   clk          - rising-edge clock
//   rst_n        - asynchronous active-low reset
//   key_valid    - one-cycle strobe qualifying key_code
//   key_code     - 0-9 digit, A clear, B enter, C backspace, D-F ignored
//   value_bcd    - entry buffer, digit 0 (most recently typed) in [3:0]
//   digit_cnt    - number of digits currently entered (0..DIGITS)
//   busy         - high while converting; keys are dropped while high
//   value_bin    - binary value of the last commit
//   result_valid - one-cycle pulse when value_bin/over_range update
//   over_range   - value_bin > MAX_VAL, held until next commit or clear
module bcd_entry_validator #(
  parameter int DIGITS  = 4,
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   value_bcd,
  output logic [3:0]            digit_cnt,
  output logic                  busy,
  output logic [BIN_W-1:0]      value_bin,
  output logic                  result_valid,
  output logic                  over_range
);

  localparam int BUF_W = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [3:0]       DIGITS_L = 4'(DIGITS);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DIGITS - 1);
  localparam logic [BIN_W-1:0] MAX_L    = BIN_W'(MAX_VAL);

  typedef enum logic {
    ENTRY,
    CONV
  } state_t;

  state_t            state;
  logic              fresh;
  logic [BIN_W-1:0]  acc;
  logic [IDX_W-1:0]  idx;

  logic [3:0]        cur_digit;
  logic [BIN_W-1:0]  acc_next;

  // One Horner step: acc*10 + digit. The multiply is two shifts and an add.
  // The sum is truncated to BIN_W.
  always_comb begin
    cur_digit = value_bcd[{idx, 2'b00} +: 4];
    acc_next  = (acc << 3) + (acc << 1) + BIN_W'(cur_digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ENTRY;
      fresh        <= 1'b0;
      acc          <= '0;
      idx          <= '0;
      value_bcd    <= '0;
      digit_cnt    <= '0;
      busy         <= 1'b0;
      value_bin    <= '0;
      result_valid <= 1'b0;
      over_range   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ENTRY: begin
          if (key_valid) begin
            case (key_code)
              4'hA: begin
                // Clear leaves the last committed binary value in place.
                value_bcd  <= '0;
                digit_cnt  <= '0;
                over_range <= 1'b0;
                fresh      <= 1'b0;
              end
              4'hB: begin
                state <= CONV;
                busy  <= 1'b1;
                acc   <= '0;
                idx   <= IDX_TOP;
                fresh <= 1'b0;
              end
              4'hC: begin
                value_bcd <= value_bcd >> 4;
                if (digit_cnt != 4'd0) begin
                  digit_cnt <= digit_cnt - 4'd1;
                end
                fresh <= 1'b0;
              end
              4'hD, 4'hE, 4'hF: begin
              end
              default: begin
                // The first digit after a commit starts a new entry.
                // It does not extend the old one.
                if (fresh) begin
                  value_bcd <= BUF_W'(key_code);
                  digit_cnt <= 4'd1;
                  fresh     <= 1'b0;
                end else if (digit_cnt < DIGITS_L) begin
                  value_bcd <= (value_bcd << 4) | BUF_W'(key_code);
                  digit_cnt <= digit_cnt + 4'd1;
                end
              end
            endcase
          end
        end
        CONV: begin
          acc <= acc_next;
          idx <= idx - 1'b1;
          if (idx == '0) begin
            value_bin    <= acc_next;
            over_range   <= (acc_next > MAX_L);
            result_valid <= 1'b1;
            fresh        <= 1'b1;
            busy         <= 1'b0;
            state        <= ENTRY;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_entry_validator.md
# bcd_entry_validator

Parametrised keypad entry and range-check block. It accumulates decimal key presses into a DIGITS-wide BCD buffer with clear and backspace editing. On an enter key it converts the buffer serially to binary, one digit per cycle, and flags whether the value exceeds MAX_VAL. It sits between the keypad decoder and the calculator operand registers, and drives the over-range LED.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits held (1..8).
- BIN_W, 14: binary result width; must satisfy 2^BIN_W > 10^DIGITS - 1.
- MAX_VAL, 127: largest in-range value, unsigned, BIN_W bits.

Ports:
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous, active-low reset.
- key_valid  in  1: one-cycle strobe; key_code is sampled when high.
- key_code  in  4: 0x0-0x9 digit, 0xA clear, 0xB enter, 0xC backspace; 0xD-0xF ignored.
- value_bcd  out  4*DIGITS: entry buffer; digit 0 is in [3:0].
- digit_cnt  out  4: digits currently entered, 0..DIGITS.
- busy  out  1: high while converting; keys are ignored while high.
- value_bin  out  BIN_W: binary value from the last commit.
- result_valid  out  1: one-cycle pulse when value_bin and over_range update.
- over_range  out  1: value_bin > MAX_VAL, held until the next commit or clear; drives LED.

## Operation
- States: ENTRY, CONV. Reset and all exits from CONV go to ENTRY.
- A registered flag `fresh` is set by a completed commit and cleared by any accepted key.
- ENTRY, digit key:
  - If `fresh`: the buffer is cleared, the digit is loaded into digit 0, and digit_cnt=1.
  - Else if digit_cnt < DIGITS: the buffer shifts left 4 bits, the digit enters digit 0, and digit_cnt increments.
  - Else (buffer full): the key is ignored and the buffer is unchanged.
- ENTRY, backspace:
  - The buffer shifts right 4 bits and zero fills the top digit.
  - digit_cnt decrements, saturating at 0.
  - Backspace on an empty buffer is a no-op.
- ENTRY, clear:
  - Zeroes value_bcd, digit_cnt and over_range.
  - value_bin is retained.
- ENTRY, enter:
  - Moves to CONV with accumulator=0 and index=DIGITS-1.
  - An empty buffer converts to 0.
- CONV: each cycle, accumulator = accumulator*10 + value_bcd digit[index], and index decrements.
  - The multiply by 10 is implemented as (acc<<3)+(acc<<1), truncated to BIN_W.
  - On the digit-0 step, the result is written to value_bin and over_range is set to (result > MAX_VAL).
  - On that same step, result_valid pulses, `fresh` is set, and the state returns to ENTRY.
- The buffer is not modified during CONV.
- BCD digits above 9 cannot enter the buffer, because only codes 0-9 are loaded.
- Keys presented while busy=1 are dropped, not queued.
- Codes 0xD-0xF are dropped in every state.

## Timing
- Reset values: value_bcd=0, digit_cnt=0, busy=0, value_bin=0, result_valid=0, over_range=0, `fresh`=0, state ENTRY.
- Reset is asynchronous: asserting rst_n low mid-CONV immediately forces all of the reset values. No partial result is written.
- An edit key sampled at edge N is visible on value_bcd and digit_cnt after edge N.
- Enter sampled at edge N:
  - busy is high for the DIGITS cycles following edge N.
  - The digit steps occur on edges N+1..N+DIGITS.
  - result_valid is high for exactly the one cycle after edge N+DIGITS, and busy is low in that same cycle.
  - value_bin and over_range change only at edge N+DIGITS.
- Latency from enter to result: DIGITS cycles.
- A key sampled in the result_valid cycle is accepted normally, with `fresh` semantics applying.
- Back-to-back enters without an edit reconvert the same buffer and give the same result.

## Test plan
Benches run with DIGITS=4, MAX_VAL=127.
- Reset release -> every output is 0; hold 3 cycles with no keys -> outputs are unchanged.
- Keys 1,2,7 then enter -> value_bcd=0x0127 and digit_cnt=3; busy is high for 4 cycles; result_valid pulses once; value_bin=127 and over_range=0.
- Keys 1,2,8 then enter -> value_bin=128 and over_range=1; the next enter, with no edit -> value_bin=128 again.
- Keys 9,9,9,9,3 -> the 5th digit is ignored and value_bcd=0x9999; enter -> value_bin=9999 and over_range=1; then backspace -> value_bcd=0x0999 and digit_cnt=3.
- Key 5 sent while busy -> dropped and value_bcd is unchanged; rst_n pulsed low 2 cycles into CONV -> all outputs are 0 at once, and no result_valid follows.
- After a commit of 127, key 4 -> value_bcd=0x0004 and digit_cnt=1; then clear -> value_bcd=0 and over_range=0, while value_bin stays 127; codes 0xE and 0xF -> no change.
